// File: rtl/alu_shift_if.sv
// Request/response bundle for the sequential shift unit.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface alu_shift_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [CW-1:0]    b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r, carry, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r, carry, zero
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock, five modes plus pass-through.
// The work register doubles as the result; carry/zero are settled by the time DONE is entered.
module alu_shift_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_shift_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    eff;
  logic [WIDTH:0]   stepped;

  // Returns {bit shifted out, next work value} for a single step.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] v, input logic [2:0] o);
    case (o)
      3'b000:  step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      3'b001:  step = {v[0], 1'b0, v[WIDTH-1:1]};
      3'b010:  step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      3'b011:  step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  step = {v[0], v[0], v[WIDTH-1:1]};
      default: step = {1'b0, v};
    endcase
  endfunction

  // Shifts saturate at WIDTH steps; rotates wrap modulo WIDTH.
  always_comb begin
    eff = '0;
    case (bus.op)
      3'b000, 3'b001, 3'b010: eff = (bus.b >= CW'(WIDTH)) ? CW'(WIDTH) : bus.b;
      3'b011, 3'b100:         eff = CW'(bus.b[SW-1:0]);
      default:                eff = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    stepped = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_d     = bus.a;
          carry_d = 1'b0;
          op_d    = bus.op;
          cnt_d   = eff;
          if (eff == '0) begin
            state_d = S_DONE;
            zero_d  = (bus.a == '0);
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        stepped = step(w_q, op_q);
        w_d     = stepped[WIDTH-1:0];
        carry_d = stepped[WIDTH];
        zero_d  = (stepped[WIDTH-1:0] == '0);
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.r         = w_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;
endmodule
